// File: rtl/core_pkg.sv
// Shared types for the RV32I core: opcodes, decoded action, sequencer state, trap cause.
package core_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [2:0]  F3_FETCH  = 3'b010;         // fetches are always full words

   typedef enum logic [2:0] {
      IS_ALU, IS_LOAD, IS_STORE, IS_BRANCH, IS_JUMP, IS_LUI, IS_AUIPC, IS_ILLEGAL
   } action_t;

   typedef enum logic [2:0] {
      FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, HALT
   } seq_state_t;

   typedef enum logic [1:0] {
      TRAP_NONE, TRAP_FETCH_MISALIGN, TRAP_DATA_MISALIGN, TRAP_ILLEGAL
   } trap_t;

   // Opcode to action class, used by the core decoder.
   function automatic action_t decode_action(input logic [6:0] opcode);
      case (opcode)
         OP_IMM, OP_REG:  return IS_ALU;
         OP_LOAD:         return IS_LOAD;
         OP_STORE:        return IS_STORE;
         OP_BRANCH:       return IS_BRANCH;
         OP_JAL, OP_JALR: return IS_JUMP;
         OP_LUI:          return IS_LUI;
         OP_AUIPC:        return IS_AUIPC;
         default:         return IS_ILLEGAL;
      endcase
   endfunction

   // func3[1:0] encodes size: 00 byte, 01 half, 10 word.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      case (f3[1:0])
         2'b10:   return (addr_lo != 2'b00);
         2'b01:   return addr_lo[0];
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter, wraps modulo 2^WIDTH.
module perf_counter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   // Count enabled cycles; synchronous clear.
   always_ff @(posedge clk) begin
      if (reset)   count <= '0;
      else if (en) count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute sequencer with a valid/ready request channel and a
// response-valid channel, traps with a sticky halt, and perf counters.
module core_sequencer
   import core_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR    = 32'h0000_0000,
   parameter int              CNT_WIDTH       = 64,
   parameter int              TRAP_MISALIGNED = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [XLEN-1:0]      mem_req_addr,
   output logic                 mem_req_wen,
   output logic [XLEN-1:0]      mem_req_wdata,
   output logic [2:0]           mem_req_func3,
   input  logic                 mem_rsp_valid,
   input  logic [XLEN-1:0]      mem_rsp_data,
   input  action_t              action_type,
   input  logic [2:0]           func3,
   input  logic [XLEN-1:0]      data_addr,
   input  logic [XLEN-1:0]      store_data,
   input  logic [XLEN-1:0]      pc_next,
   output logic [XLEN-1:0]      pc,
   output logic [31:0]          instruction,
   output logic [XLEN-1:0]      load_data,
   output logic                 reg_wen,
   output logic                 halted,
   output trap_t                trap_cause,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instret_count
);

   seq_state_t state, state_nxt;
   trap_t      trap_nxt;
   // Once a fetch is offered it must stay offered until accepted, even if run drops.
   logic       fetch_hold;

   assign halted = (state == HALT);

   // Next-state and request/strobe decode.
   always_comb begin
      state_nxt     = state;
      trap_nxt      = trap_cause;
      mem_req_valid = 1'b0;
      mem_req_addr  = pc;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_func3 = F3_FETCH;
      reg_wen       = 1'b0;
      case (state)
         FETCH_REQ: begin
            if (pc[1:0] != 2'b00) begin
               state_nxt = HALT;
               trap_nxt  = TRAP_FETCH_MISALIGN;
            end else if (run || fetch_hold) begin
               mem_req_valid = 1'b1;
               if (mem_req_ready) state_nxt = FETCH_WAIT;
            end
         end
         FETCH_WAIT: if (mem_rsp_valid) state_nxt = DECODE;
         DECODE:     state_nxt = EXECUTE;
         EXECUTE: begin
            case (action_type)
               IS_ILLEGAL: begin
                  state_nxt = HALT;
                  trap_nxt  = TRAP_ILLEGAL;
               end
               IS_LOAD, IS_STORE: begin
                  if ((TRAP_MISALIGNED != 0) && is_misaligned(func3, data_addr[1:0])) begin
                     state_nxt = HALT;
                     trap_nxt  = TRAP_DATA_MISALIGN;
                  end else begin
                     state_nxt = MEM_REQ;
                  end
               end
               default: state_nxt = WRITEBACK;
            endcase
         end
         MEM_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = data_addr;
            mem_req_func3 = func3;
            if (action_type == IS_STORE) begin
               mem_req_wen   = 1'b1;
               mem_req_wdata = store_data;
            end
            // Stores complete on acceptance; loads wait for data.
            if (mem_req_ready) state_nxt = (action_type == IS_STORE) ? WRITEBACK : MEM_WAIT;
         end
         MEM_WAIT:  if (mem_rsp_valid) state_nxt = WRITEBACK;
         WRITEBACK: begin
            reg_wen   = (action_type != IS_STORE) && (action_type != IS_BRANCH);
            state_nxt = FETCH_REQ;
         end
         HALT:      state_nxt = HALT;
         default:   state_nxt = FETCH_REQ;
      endcase
      // No request may be offered while reset is applied.
      if (reset) mem_req_valid = 1'b0;
   end

   // State, PC, instruction/load latches and trap cause.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH_REQ;
         pc          <= RESET_VECTOR;
         instruction <= NOP_INSTR;
         load_data   <= '0;
         trap_cause  <= TRAP_NONE;
         fetch_hold  <= 1'b0;
      end else begin
         state      <= state_nxt;
         trap_cause <= trap_nxt;
         fetch_hold <= (state == FETCH_REQ) && mem_req_valid && !mem_req_ready;
         if ((state == FETCH_WAIT) && mem_rsp_valid) instruction <= mem_rsp_data[31:0];
         if ((state == MEM_WAIT) && mem_rsp_valid)   load_data   <= mem_rsp_data;
         if (state == WRITEBACK)                     pc          <= pc_next;
      end
   end

   perf_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (state != HALT),
      .count (cycle_count)
   );

   perf_counter #(.WIDTH(CNT_WIDTH)) u_instret_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (state == WRITEBACK),
      .count (instret_count)
   );

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
   logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
   logic [2:0]  mem_req_func3, func3;
   action_t     action_type;
   logic [31:0] data_addr, store_data, pc_next, pc, instruction, load_data;
   logic        reg_wen, halted;
   trap_t       trap_cause;
   logic [63:0] cycle_count, instret_count;

   always #5 clk = ~clk;

   core_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(64), .TRAP_MISALIGNED(1)) dut (
      .clk(clk), .reset(reset), .run(run),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_func3(mem_req_func3),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .action_type(action_type), .func3(func3), .data_addr(data_addr), .store_data(store_data),
      .pc_next(pc_next), .pc(pc), .instruction(instruction), .load_data(load_data),
      .reg_wen(reg_wen), .halted(halted), .trap_cause(trap_cause),
      .cycle_count(cycle_count), .instret_count(instret_count)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- core stand-in: decode, operands, next PC ----------------
   int          pc_step = 4;
   logic [6:0]  opc;
   logic [31:0] i_imm, s_imm;

   function automatic action_t tb_class(input logic [6:0] o);
      if (o == 7'b0010011 || o == 7'b0110011) return IS_ALU;
      if (o == 7'b0000011) return IS_LOAD;
      if (o == 7'b0100011) return IS_STORE;
      if (o == 7'b1100011) return IS_BRANCH;
      if (o == 7'b1101111 || o == 7'b1100111) return IS_JUMP;
      if (o == 7'b0110111) return IS_LUI;
      if (o == 7'b0010111) return IS_AUIPC;
      return IS_ILLEGAL;
   endfunction

   always_comb begin
      opc         = instruction[6:0];
      action_type = tb_class(opc);
      func3       = instruction[14:12];
      i_imm       = {{20{instruction[31]}}, instruction[31:20]};
      s_imm       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      data_addr   = (opc == 7'b0100011) ? s_imm : i_imm;   // rs1 is always x0
      store_data  = 32'hC0DE_0000 ^ pc;
      pc_next     = pc + pc_step;
   end

   // ---------------- memory model + monitor ----------------
   logic [31:0] mem [logic [31:0]];
   int rdy_delay = 0, lat_f = 1, lat_d = 1;
   int wait_cnt = 0, rem = 0, cs = 0, last_cs = 0;
   bit stall_prev = 0;
   logic [31:0] s_addr, s_wdata, rsp_word;
   logic        s_wen;
   logic [2:0]  s_f3;

   typedef struct {
      int          cyc;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [2:0]  f3;
   } hs_t;
   hs_t hs_log[$];
   int  wen_log[$];

   function automatic logic [31:0] fill_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      logic [31:0] w = {a[31:2], 2'b00};
      if (mem.exists(w)) return mem[w];
      return fill_word(w);
   endfunction

   initial begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   end

   always begin
      @(negedge clk);
      if (reset) begin
         cs = 0; wait_cnt = 0; rem = 0; stall_prev = 0;
         hs_log.delete(); wen_log.delete();
      end else begin
         last_cs = cs;
         if (stall_prev) begin
            checks++;
            assert (mem_req_valid === 1'b1 && mem_req_addr === s_addr && mem_req_wen === s_wen &&
                    mem_req_wdata === s_wdata && mem_req_func3 === s_f3)
            else begin
               errors++;
               $error("FAIL req_stable cyc %0d observed v=%b a=%h w=%b d=%h f=%0d expected v=1 a=%h w=%b d=%h f=%0d",
                      cs, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_func3,
                      s_addr, s_wen, s_wdata, s_f3);
            end
         end
         if (reg_wen) wen_log.push_back(cs);
         if (rem > 0) rem--;
         if (mem_req_valid && mem_req_ready) begin
            hs_log.push_back('{cs, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_func3});
            wait_cnt = 0; stall_prev = 0;
            if (!mem_req_wen) begin
               rem      = (mem_req_addr < 32'h100) ? lat_f : lat_d;
               rsp_word = mem_read(mem_req_addr);
            end
         end else if (mem_req_valid) begin
            wait_cnt++; stall_prev = 1;
            s_addr = mem_req_addr; s_wen = mem_req_wen; s_wdata = mem_req_wdata; s_f3 = mem_req_func3;
         end else begin
            stall_prev = 0;
         end
         cs++;
      end
      @(posedge clk); #1;
      mem_req_ready = (wait_cnt >= rdy_delay);
      mem_rsp_valid = (rem == 1);
      mem_rsp_data  = (rem == 1) ? rsp_word : $urandom;
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic to_cycle_end();
      @(negedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1 reset = 1'b1;
      repeat (n) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_until(input int n, input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         to_cycle_end();
         if (instret_count == 64'(n) || halted) begin
            c = last_cs;
            break;
         end
      end
      checks++;
      assert (c >= 0)
      else begin
         errors++;
         $error("FAIL run_timeout observed instret %0d expected %0d within %0d cycles", instret_count, n, budget);
      end
   endtask

   task automatic load_prog(input logic [31:0] w0);
      mem.delete();
      mem[32'h0] = w0;
   endtask

   // ---------------- directed + random sequence ----------------
   localparam logic [31:0] ADDI   = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] LW100  = 32'h1000_2103;  // lw x2,0x100(x0)
   localparam logic [31:0] SW102  = 32'h1010_2123;  // sw x1,0x102(x0)
   localparam logic [31:0] ILLEG  = 32'hFFFF_FFFF;

   initial begin
      int c;
      int exp_cyc, exp_wen, d, lf, ld;
      logic [31:0] exp_ld;
      logic [31:0] prog_w;
      logic [31:0] st_addr[$], st_data[$];
      logic [2:0]  st_f3[$];
      hs_t         st_seen[$];
      bit          any_ld;

      // Reset values
      load_prog(ADDI);
      run = 1'b1;
      repeat (2) @(posedge clk);
      to_cycle_end();
      chk("rst_pc", pc, 0);
      chk("rst_instr", instruction, 32'h13);
      chk("rst_load", load_data, 0);
      chk("rst_valid", mem_req_valid, 0);
      chk("rst_wen", reg_wen, 0);
      chk("rst_halted", halted, 0);
      chk("rst_trap", trap_cause, TRAP_NONE);
      chk("rst_cyc", cycle_count, 0);
      chk("rst_inst", instret_count, 0);
      @(posedge clk); #1 reset = 1'b0;

      // ADDI, zero wait states
      run_until(1, 50, c);
      chk("addi_lat", c, 5);
      chk("addi_cyc", cycle_count, 5);
      chk("addi_wen_n", wen_log.size(), 1);
      if (wen_log.size() > 0) chk("addi_wen_cyc", wen_log[0], 4);
      chk("addi_hs_n", hs_log.size(), 2);
      if (hs_log.size() == 2) begin
         chk("addi_f0", {hs_log[0].cyc, hs_log[0].addr, 29'(0), hs_log[0].f3}, {32'd0, 32'h0, 29'(0), 3'b010});
         chk("addi_f1", {hs_log[1].cyc, hs_log[1].addr}, {32'd5, 32'h4});
      end

      // run gate plus 3-cycle ready stall, run dropped while stalled
      run = 1'b0; rdy_delay = 3;
      do_reset(1);
      to_cycle_end();
      chk("gate_v0", mem_req_valid, 0);
      to_cycle_end();
      chk("gate_v1", mem_req_valid, 0);
      chk("gate_cyc", cycle_count, 1);
      @(posedge clk); #1 run = 1'b1;
      to_cycle_end();
      @(posedge clk); #1 run = 1'b0;
      run_until(1, 50, c);
      chk("stall_lat", c, 10);
      chk("stall_hs_n", hs_log.size(), 1);
      if (hs_log.size() > 0) chk("stall_hs", {hs_log[0].cyc, hs_log[0].addr}, {32'd5, 32'h0});
      if (wen_log.size() > 0) chk("stall_wen", wen_log[0], 9);
      to_cycle_end();
      chk("gate_v_post", mem_req_valid, 0);
      chk("gate_cyc_post", cycle_count, 11);
      run = 1'b1; rdy_delay = 0;

      // LW, 4-cycle data latency
      load_prog(LW100); mem[32'h100] = 32'hDEAD_BEEF; lat_d = 4;
      do_reset(1);
      run_until(1, 50, c);
      chk("lw_lat", c, 10);
      chk("lw_data", load_data, 32'hDEAD_BEEF);
      chk("lw_wen_n", wen_log.size(), 1);
      if (wen_log.size() > 0) chk("lw_wen_cyc", wen_log[0], 9);
      if (hs_log.size() > 1)
         chk("lw_req", {hs_log[1].cyc, hs_log[1].addr, 31'(0), hs_log[1].wen, 29'(0), hs_log[1].f3},
             {32'd4, 32'h100, 31'(0), 1'b0, 29'(0), 3'b010});
      lat_d = 1;

      // misaligned store traps before any request
      load_prog(SW102);
      do_reset(1);
      repeat (10) to_cycle_end();
      chk("sw_halt", halted, 1);
      chk("sw_trap", trap_cause, TRAP_DATA_MISALIGN);
      chk("sw_cyc", cycle_count, 4);
      chk("sw_inst", instret_count, 0);
      chk("sw_pc", pc, 0);
      chk("sw_instr", instruction, SW102);
      chk("sw_hs_n", hs_log.size(), 1);
      chk("sw_valid", mem_req_valid, 0);

      // illegal instruction, then 1-cycle reset recovers
      load_prog(ILLEG);
      do_reset(1);
      repeat (8) to_cycle_end();
      chk("ill_halt", halted, 1);
      chk("ill_trap", trap_cause, TRAP_ILLEGAL);
      chk("ill_cyc", cycle_count, 4);
      do_reset(1);
      to_cycle_end();
      chk("ill_rst_pc", pc, 0);
      chk("ill_rst_halt", halted, 0);
      chk("ill_rst_fetch", {31'(0), mem_req_valid, mem_req_addr}, {31'(0), 1'b1, 32'h0});

      // next PC not word aligned
      load_prog(ADDI); pc_step = 2;
      do_reset(1);
      repeat (10) to_cycle_end();
      chk("fmis_trap", trap_cause, TRAP_FETCH_MISALIGN);
      chk("fmis_pc", pc, 2);
      chk("fmis_inst", instret_count, 1);
      chk("fmis_cyc", cycle_count, 6);
      pc_step = 4;

      // reset while a load waits for data
      load_prog(LW100); lat_d = 4;
      do_reset(1);
      repeat (6) to_cycle_end();
      chk("rmw_wen_before", wen_log.size(), 0);
      do_reset(1);
      to_cycle_end();
      chk("rmw_cyc", cycle_count, 0);
      chk("rmw_inst", instret_count, 0);
      chk("rmw_fetch", {31'(0), mem_req_valid, mem_req_addr}, {31'(0), 1'b1, 32'h0});
      repeat (5) to_cycle_end();
      chk("rmw_wen_after", wen_log.size(), 0);

      // random programs against a cycle/effect model
      for (int t = 0; t < 4; t++) begin
         d = $urandom_range(0, 2); lf = $urandom_range(1, 3); ld = $urandom_range(1, 3);
         rdy_delay = d; lat_f = lf; lat_d = ld;
         mem.delete(); st_addr.delete(); st_data.delete(); st_f3.delete();
         exp_cyc = 0; exp_wen = 0; exp_ld = 0; any_ld = 0;
         for (int i = 0; i < 12; i++) begin
            int          k = $urandom_range(0, 5);
            logic [31:0] a;
            logic [2:0]  f;
            exp_cyc += (1 + d) + lf + 2;
            case (k)
               0: prog_w = {12'($urandom), 5'd0, 3'b000, 5'd1, 7'b0010011};
               1: prog_w = {20'($urandom), 5'd3, 7'b0110111};
               2: prog_w = {7'd0, 5'd0, 5'd0, 3'b000, 5'd8, 7'b1100011};
               3: prog_w = {20'($urandom), 5'd1, 7'b1101111};
               4: begin
                  case ($urandom_range(0, 4))
                     0: f = 3'b000; 1: f = 3'b001; 2: f = 3'b010; 3: f = 3'b100; default: f = 3'b101;
                  endcase
                  a = 32'h100 + 32'($urandom_range(0, 63));
                  if (f[1:0] == 2'b10) a[1:0] = 2'b00;
                  if (f[1:0] == 2'b01) a[0] = 1'b0;
                  prog_w = {a[11:0], 5'd0, f, 5'd4, 7'b0000011};
               end
               default: begin
                  f = 3'($urandom_range(0, 2));
                  a = 32'h200 + 32'($urandom_range(0, 63));
                  if (f == 3'b010) a[1:0] = 2'b00;
                  if (f == 3'b001) a[0] = 1'b0;
                  prog_w = {a[11:5], 5'd5, 5'd0, f, a[4:0], 7'b0100011};
               end
            endcase
            mem[32'(i * 4)] = prog_w;
            if (k == 4) begin
               exp_cyc += (1 + d) + ld + 1; exp_wen++;
               exp_ld = fill_word({a[31:2], 2'b00}); any_ld = 1;
            end else if (k == 5) begin
               exp_cyc += (1 + d) + 1;
               st_addr.push_back(a); st_data.push_back(32'hC0DE_0000 ^ 32'(i * 4)); st_f3.push_back(f);
            end else begin
               exp_cyc += 1;
               if (k != 2) exp_wen++;
            end
         end
         do_reset(1);
         run_until(12, 600, c);
         chk("rnd_lat", c, exp_cyc);
         chk("rnd_cyc", cycle_count, exp_cyc);
         chk("rnd_wen_n", wen_log.size(), exp_wen);
         if (any_ld) chk("rnd_ld", load_data, exp_ld);
         st_seen.delete();
         foreach (hs_log[j]) if (hs_log[j].wen) st_seen.push_back(hs_log[j]);
         chk("rnd_st_n", st_seen.size(), st_addr.size());
         if (st_seen.size() == st_addr.size())
            foreach (st_seen[j]) begin
               chk("rnd_st_addr", {st_seen[j].f3, st_seen[j].addr}, {st_f3[j], st_addr[j]});
               chk("rnd_st_data", st_seen[j].wdata, st_data[j]);
            end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
